hazard_ctl: RTL and testbench
=============================

// Module: hazard_ctl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS-Lite core. Drives PC/IF_ID enables, the ID_EX bubble and the IF_ID flush.
//  Drives EX- and ID-stage forwarding selects. Tracks multiplier occupancy so dependent instructions stall until HiLo is valid.
//  Sits beside the ID stage and replaces the tied-high en_reg on PC, IF_ID and ID_EX.
// PARAMETERS
//  MUL_LAT   32  cycles from multu entering EX until HiLo holds the result (>=2)
//  CNT_W     32  width of stall performance counter
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous reset, active-high
//  id_opcode     in   6      opcode of instr in IF_ID
//  id_funct      in   6      funct of instr in IF_ID
//  id_rs, id_rt  in   5      source regs of instr in IF_ID
//  id_taken      in   1      PCSrc | Jump | JumpR (redirect resolved in ID)
//  ex_rs, ex_rt  in   5      source regs held in ID_EX
//  ex_memread    in   1      ID_EX MEM_reg[0] (load in EX)
//  ex_regwrite   in   1      ID_EX WB_reg[0]
//  ex_wn         in   5      destination selected by RFMUX in EX
//  ex_multu      in   1      multu in EX this cycle (from alu_ctl)
//  mem_regwrite  in   1      EX_MEM WB_reg[0]
//  mem_memread   in   1      EX_MEM MEM_reg[0]
//  mem_wn        in   5      EX_MEM destination
//  wb_regwrite   in   1      MEM_WB WB_reg[0]
//  wb_wn         in   5      MEM_WB destination
//  pc_en         out  1      PC register enable
//  ifid_en       out  1      IF_ID enable
//  ifid_flush    out  1      load NOP into IF_ID on next edge
//  idex_bubble   out  1      load zero control (WB/MEM/EX) into ID_EX on next edge
//  fwd_a, fwd_b  out  2      EX ALU operand select: 00 ID_EX, 10 EX_MEM alu, 01 MEM_WB wd
//  id_fwd_a/_b   out  2      ID compare/JR operand: 00 regfile, 10 EX_MEM alu, 01 MEM_WB wd
//  mul_busy      out  1      multiplier occupied
//  stall_cnt     out  CNT_W  number of stall cycles since reset
// BEHAVIOUR
//  Reset (rst=1 at posedge): mul state->IDLE, mul count->0, stall_cnt->0.
//   While rst=1, outputs are forced: pc_en=1, ifid_en=1, flush=0, bubble=0, all fwd=00, mul_busy=0.
//  Reads: rs is read by all opcodes except J(0x02), mfhi(0/0x10) and mflo(0/0x12).
//   rt is read by R-type, BEQ(0x04), BNE(0x05) and SW(0x2B).
//   Register 0 never matches any hazard.
//  Stall conditions (combinational, evaluated on instr in ID); stall = OR of:
//   load-use: ex_memread & ex_wn==id src (read).
//   branch/JR src: ex_regwrite & ex_wn==src, with src compared in ID (BEQ/BNE/JR).
//    A load in EX therefore costs 2 cycles: this term, then the next one.
//   branch/JR src: mem_memread & mem_wn==src.
//   mul: mul_busy & id instr is multu(0x19), mfhi or mflo.
//  On stall: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
//   A stall suppresses id_taken, so the redirect waits for valid operands.
//  No stall & id_taken: ifid_flush=1; pc_en=ifid_en=1; no bubble.
//  Forwarding (per operand, EX_MEM priority over MEM_WB):
//   fwd=10 if mem_regwrite & mem_wn!=0 & mem_wn==ex_src;
//   else 01 if wb_regwrite & wb_wn!=0 & wb_wn==ex_src; else 00.
//   id_fwd uses the same rule with id_src, and only EX_MEM non-load results are eligible for 10.
//  Multiplier FSM: IDLE --ex_multu--> BUSY, count<=MUL_LAT-1.
//   BUSY: count decrements; on count==1 -> IDLE next edge.
//   mul_busy=1 in BUSY and in the IDLE cycle where ex_multu=1.
//   ex_multu while BUSY is illegal, because the stall prevents it; a bench assertion must check this.
//  stall_cnt increments by 1 on each cycle with stall=1 and rst=0, and wraps modulo 2^CNT_W.
//  Reset mid-stall or mid-multiply: all state is cleared on that edge, with no residual stall.
// STRUCTURE
//  mips_pkg: opcode/funct localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, FN_JR, FN_MULTU, FN_MFHI, FN_MFLO).
//   It also holds the FWD_* select encodings and the MUL_IDLE/MUL_BUSY state codes.
//  Sub-module fwd_unit: the pure-combinational 2-operand priority compare, instantiated twice (EX and ID).
//  hazard_ctl keeps the stall logic, the mul FSM/counter and stall_cnt.
// TESTING
//  lw r2,0(r1); add r3,r2,r4 -> one cycle with pc_en=0, idex_bubble=1; next cycle fwd_a=01; stall_cnt=1.
//  add r2,..; sub r5,r2,r2 -> fwd_a=fwd_b=10, no stall.
//   With an unrelated instr between them -> fwd=01 on both.
//  lw r2; beq r2,r0 -> 2 stall cycles, ifid_flush=0 during both; then taken -> ifid_flush=1 for 1 cycle.
//  multu r1,r2 then mflo r3 with MUL_LAT=4 -> mul_busy high 4 cycles; mflo stalls until mul_busy falls; stall_cnt=3.
//  Writes to r0 (add r0,..; add r4,r0,r0) -> fwd=00, no stall.
//  rst=1 asserted during the multiply busy period -> next cycle mul_busy=0, stall_cnt=0, pc_en=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared decode constants, forwarding encodings and multiplier state codes
// for the MIPS-Lite pipeline control.
package mips_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned REG_W = 5;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_JR    = 6'h08;
    localparam logic [OP_W-1:0] FN_MFHI  = 6'h10;
    localparam logic [OP_W-1:0] FN_MFLO  = 6'h12;
    localparam logic [OP_W-1:0] FN_MULTU = 6'h19;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b01;

    localparam logic [0:0] MUL_IDLE = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        logic [OP_W-1:0]  funct;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
    } id_instr_t;

    // Instructions that touch the HiLo pair and must wait for the multiplier
    function automatic logic uses_hilo(input id_instr_t ins);
        return (ins.opcode == OP_RTYPE) &&
               ((ins.funct == FN_MULTU) || (ins.funct == FN_MFHI) || (ins.funct == FN_MFLO));
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Two-operand forwarding priority compare: EX_MEM result wins over MEM_WB.
module fwd_unit
    import mips_pkg::*;
(
    input  logic [REG_W-1:0] src_a,
    input  logic [REG_W-1:0] src_b,
    input  logic             mem_valid,
    input  logic [REG_W-1:0] mem_wn,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_wn,
    output logic [1:0]       sel_a_c,
    output logic [1:0]       sel_b_c
);

    function automatic logic [1:0] pick(input logic [REG_W-1:0] src);
        logic [1:0] sel;
        sel = FWD_NONE;
        if (mem_valid && (mem_wn != '0) && (mem_wn == src)) begin
            sel = FWD_MEM;
        end else if (wb_valid && (wb_wn != '0) && (wb_wn == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        sel_a_c = pick(src_a);
        sel_b_c = pick(src_b);
    end

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline sequencer: stall/flush/bubble control, EX and ID forwarding selects,
// multiplier occupancy tracking and a stall-cycle counter.
module hazard_ctl
    import mips_pkg::*;
#(
    parameter int unsigned MUL_LAT = 32,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       id_opcode,
    input  logic [5:0]       id_funct,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_taken,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_wn,
    input  logic             ex_multu,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic [4:0]       mem_wn,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_wn,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       id_fwd_a,
    output logic [1:0]       id_fwd_b,
    output logic             mul_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned MUL_CNT_W = $clog2(MUL_LAT);

    id_instr_t            id_instr;
    logic [0:0]           mul_state, mul_state_nxt;
    logic [MUL_CNT_W-1:0] mul_cnt, mul_cnt_nxt;
    logic                 busy_c;

    logic is_rtype, is_branch, is_jr;
    logic rs_read, rt_read, rs_cmp, rt_cmp;
    logic rs_nz, rt_nz;
    logic load_use, branch_haz, mul_haz, stall_c;

    logic [1:0] ex_sel_a, ex_sel_b, id_sel_a, id_sel_b;

    assign id_instr = '{opcode: id_opcode, funct: id_funct, rs: id_rs, rt: id_rt};

    // Operand usage of the instruction sitting in ID
    always_comb begin
        is_rtype  = (id_instr.opcode == OP_RTYPE);
        is_branch = (id_instr.opcode == OP_BEQ) || (id_instr.opcode == OP_BNE);
        is_jr     = is_rtype && (id_instr.funct == FN_JR);
        rs_read   = (id_instr.opcode != OP_J) &&
                    !(is_rtype && ((id_instr.funct == FN_MFHI) || (id_instr.funct == FN_MFLO)));
        rt_read   = is_rtype || is_branch || (id_instr.opcode == OP_SW);
        rs_cmp    = is_branch || is_jr;
        rt_cmp    = is_branch;
        rs_nz     = (id_instr.rs != '0);
        rt_nz     = (id_instr.rt != '0);
    end

    // Branch/JR operands are consumed in ID, so any producer still in EX, or a load in MEM, must stall
    always_comb begin
        load_use   = ex_memread &&
                     ((rs_read && rs_nz && (ex_wn == id_instr.rs)) ||
                      (rt_read && rt_nz && (ex_wn == id_instr.rt)));
        branch_haz = (rs_cmp && rs_nz &&
                      ((ex_regwrite && (ex_wn == id_instr.rs)) ||
                       (mem_memread && (mem_wn == id_instr.rs)))) ||
                     (rt_cmp && rt_nz &&
                      ((ex_regwrite && (ex_wn == id_instr.rt)) ||
                       (mem_memread && (mem_wn == id_instr.rt))));
        mul_haz    = busy_c && uses_hilo(id_instr);
        stall_c    = load_use || branch_haz || mul_haz;
    end

    // Multiplier occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            mul_state <= MUL_IDLE;
            mul_cnt   <= '0;
        end else begin
            mul_state <= mul_state_nxt;
            mul_cnt   <= mul_cnt_nxt;
        end
    end

    // Multiplier next state
    always_comb begin
        mul_state_nxt = mul_state;
        mul_cnt_nxt   = mul_cnt;
        case (mul_state)
            MUL_IDLE: begin
                if (ex_multu) begin
                    mul_state_nxt = MUL_BUSY;
                    mul_cnt_nxt   = MUL_CNT_W'(MUL_LAT - 1);
                end
            end
            MUL_BUSY: begin
                mul_cnt_nxt = mul_cnt - MUL_CNT_W'(1);
                if (mul_cnt == MUL_CNT_W'(1)) begin
                    mul_state_nxt = MUL_IDLE;
                end
            end
            default: mul_state_nxt = MUL_IDLE;
        endcase
    end

    // A multu entering EX occupies HiLo from that very cycle
    assign busy_c = (mul_state == MUL_BUSY) || ex_multu;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_c) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    fwd_unit u_fwd_ex (
        .src_a     (ex_rs),
        .src_b     (ex_rt),
        .mem_valid (mem_regwrite),
        .mem_wn    (mem_wn),
        .wb_valid  (wb_regwrite),
        .wb_wn     (wb_wn),
        .sel_a_c   (ex_sel_a),
        .sel_b_c   (ex_sel_b)
    );

    // A load in MEM has no data on the EX_MEM ALU bus yet
    fwd_unit u_fwd_id (
        .src_a     (id_instr.rs),
        .src_b     (id_instr.rt),
        .mem_valid (mem_regwrite && !mem_memread),
        .mem_wn    (mem_wn),
        .wb_valid  (wb_regwrite),
        .wb_wn     (wb_wn),
        .sel_a_c   (id_sel_a),
        .sel_b_c   (id_sel_b)
    );

    // Pipeline enables; reset forces the free-running defaults
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        fwd_a       = FWD_NONE;
        fwd_b       = FWD_NONE;
        id_fwd_a    = FWD_NONE;
        id_fwd_b    = FWD_NONE;
        mul_busy    = 1'b0;
        if (!rst) begin
            fwd_a    = ex_sel_a;
            fwd_b    = ex_sel_b;
            id_fwd_a = id_sel_a;
            id_fwd_b = id_sel_b;
            mul_busy = busy_c;
            if (stall_c) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end else if (id_taken) begin
                ifid_flush = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctl.sv
// Bench for hazard_ctl: directed pipeline scenarios with literal expectations,
// then randomized traffic checked every cycle against a rule-level model.
module tb_hazard_ctl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned N_RAND  = 4000;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] id_opcode, id_funct;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wn, mem_wn, wb_wn;
    logic id_taken, ex_memread, ex_regwrite, ex_multu;
    logic mem_regwrite, mem_memread, wb_regwrite;
    logic pc_en, ifid_en, ifid_flush, idex_bubble, mul_busy;
    logic [1:0] fwd_a, fwd_b, id_fwd_a, id_fwd_b;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    int m_cnt = 0;
    int m_stall_cnt = 0;

    logic [5:0] op_tab[8] = '{6'h00, 6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08};
    logic [5:0] fn_tab[6] = '{6'h20, 6'h22, 6'h08, 6'h19, 6'h10, 6'h12};

    always #5 clk = ~clk;

    hazard_ctl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_opcode(id_opcode), .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt),
        .id_taken(id_taken), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wn(ex_wn),
        .ex_multu(ex_multu), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
        .mem_wn(mem_wn), .wb_regwrite(wb_regwrite), .wb_wn(wb_wn),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b), .mul_busy(mul_busy),
        .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // Model: remaining busy cycles after a multu; busy also in the multu's own EX cycle
    function automatic bit m_busy();
        return (m_cnt != 0) || ex_multu;
    endfunction

    function automatic bit m_stall();
        logic [4:0] src[2];
        bit rd[2];
        bit cmp[2];
        bit s, rtype, br, jr;
        rtype  = (id_opcode == 6'h00);
        br     = (id_opcode == 6'h04) || (id_opcode == 6'h05);
        jr     = rtype && (id_funct == 6'h08);
        src[0] = id_rs;
        src[1] = id_rt;
        rd[0]  = !((id_opcode == 6'h02) || (rtype && (id_funct == 6'h10 || id_funct == 6'h12)));
        rd[1]  = rtype || br || (id_opcode == 6'h2B);
        cmp[0] = br || jr;
        cmp[1] = br;
        s = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (src[i] != 5'd0) begin
                if (rd[i] && ex_memread && ex_wn == src[i]) s = 1'b1;
                if (cmp[i] && ex_regwrite && ex_wn == src[i]) s = 1'b1;
                if (cmp[i] && mem_memread && mem_wn == src[i]) s = 1'b1;
            end
        end
        if (m_busy() && rtype && (id_funct == 6'h19 || id_funct == 6'h10 || id_funct == 6'h12)) s = 1'b1;
        return s;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] src, input bit mem_ok);
        if (src != 5'd0 && mem_regwrite && mem_ok && mem_wn == src) return 2'b10;
        if (src != 5'd0 && wb_regwrite && wb_wn == src) return 2'b01;
        return 2'b00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt       <= 0;
            m_stall_cnt <= 0;
        end else begin
            if (m_stall()) m_stall_cnt <= (m_stall_cnt + 1) % (1 << CNT_W);
            if (m_cnt != 0) m_cnt <= m_cnt - 1;
            else if (ex_multu) m_cnt <= MUL_LAT - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(ex_multu && m_cnt != 0))
                else $error("FAIL ex_multu_while_busy at %0t", $time);
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        bit s;
        if (cmp_on) begin
            s = !rst && m_stall();
            chk("pc_en", 32'(pc_en), 32'(!s));
            chk("ifid_en", 32'(ifid_en), 32'(!s));
            chk("idex_bubble", 32'(idex_bubble), 32'(s));
            chk("ifid_flush", 32'(ifid_flush), 32'(!rst && !s && id_taken));
            chk("fwd_a", 32'(fwd_a), rst ? 32'd0 : 32'(m_fwd(ex_rs, 1'b1)));
            chk("fwd_b", 32'(fwd_b), rst ? 32'd0 : 32'(m_fwd(ex_rt, 1'b1)));
            chk("id_fwd_a", 32'(id_fwd_a), rst ? 32'd0 : 32'(m_fwd(id_rs, !mem_memread)));
            chk("id_fwd_b", 32'(id_fwd_b), rst ? 32'd0 : 32'(m_fwd(id_rt, !mem_memread)));
            chk("mul_busy", 32'(mul_busy), 32'(!rst && m_busy()));
            chk("stall_cnt", 32'(stall_cnt), 32'(m_stall_cnt));
        end
    end

    task automatic idle();
        rst = 1'b0; id_opcode = 6'h00; id_funct = 6'h00; id_rs = 5'd0; id_rt = 5'd0;
        id_taken = 1'b0; ex_rs = 5'd0; ex_rt = 5'd0; ex_memread = 1'b0; ex_regwrite = 1'b0;
        ex_wn = 5'd0; ex_multu = 1'b0; mem_regwrite = 1'b0; mem_memread = 1'b0; mem_wn = 5'd0;
        wb_regwrite = 1'b0; wb_wn = 5'd0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #5;
    endtask

    task automatic id_set(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                          input logic [4:0] rt, input logic taken);
        id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; id_taken = taken;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        id_set(6'h00, 6'h12, 5'd0, 5'd0, 1'b1);
        cmp_on = 1'b1;
        next();
        settle();
        chk("rst_forced_pc_en", 32'(pc_en), 32'd1);
        chk("rst_forced_flush", 32'(ifid_flush), 32'd0);
        next();
        idle();
        settle();
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("reset_mul_busy", 32'(mul_busy), 32'd0);

        // lw r2 in EX; add r3,r2,r4 in ID
        next(); idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wn = 5'd2;
        id_set(6'h00, 6'h20, 5'd2, 5'd4, 1'b0);
        settle();
        chk("lu_pc_en", 32'(pc_en), 32'd0);
        chk("lu_bubble", 32'(idex_bubble), 32'd1);
        next(); idle();
        mem_memread = 1'b1; mem_regwrite = 1'b1; mem_wn = 5'd2;
        id_set(6'h00, 6'h20, 5'd2, 5'd4, 1'b0);
        settle();
        chk("lu_release", 32'(pc_en), 32'd1);
        next(); idle();
        wb_regwrite = 1'b1; wb_wn = 5'd2; ex_rs = 5'd2; ex_rt = 5'd4;
        settle();
        chk("lu_fwd_a", 32'(fwd_a), 32'd1);
        chk("lu_fwd_b", 32'(fwd_b), 32'd0);
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

        // add r2 ; sub r5,r2,r2  (adjacent, then one apart)
        next(); idle();
        mem_regwrite = 1'b1; mem_wn = 5'd2; ex_rs = 5'd2; ex_rt = 5'd2;
        settle();
        chk("adj_fwd_a", 32'(fwd_a), 32'd2);
        chk("adj_fwd_b", 32'(fwd_b), 32'd2);
        next(); idle();
        mem_regwrite = 1'b1; mem_wn = 5'd9; wb_regwrite = 1'b1; wb_wn = 5'd2;
        ex_rs = 5'd2; ex_rt = 5'd2;
        settle();
        chk("gap_fwd_a", 32'(fwd_a), 32'd1);
        chk("gap_fwd_b", 32'(fwd_b), 32'd1);

        // lw r2 ; beq r2,r0 taken
        next(); idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wn = 5'd2;
        id_set(6'h04, 6'h00, 5'd2, 5'd0, 1'b1);
        settle();
        chk("br1_pc_en", 32'(pc_en), 32'd0);
        chk("br1_flush", 32'(ifid_flush), 32'd0);
        next(); idle();
        mem_memread = 1'b1; mem_regwrite = 1'b1; mem_wn = 5'd2;
        id_set(6'h04, 6'h00, 5'd2, 5'd0, 1'b1);
        settle();
        chk("br2_bubble", 32'(idex_bubble), 32'd1);
        chk("br2_flush", 32'(ifid_flush), 32'd0);
        next(); idle();
        wb_regwrite = 1'b1; wb_wn = 5'd2;
        id_set(6'h04, 6'h00, 5'd2, 5'd0, 1'b1);
        settle();
        chk("br3_flush", 32'(ifid_flush), 32'd1);
        chk("br3_id_fwd_a", 32'(id_fwd_a), 32'd1);
        next(); idle();
        settle();
        chk("br4_flush", 32'(ifid_flush), 32'd0);

        // ALU result in MEM feeds a branch directly; a load in MEM does not
        next(); idle();
        mem_regwrite = 1'b1; mem_wn = 5'd7;
        id_set(6'h05, 6'h00, 5'd7, 5'd3, 1'b0);
        settle();
        chk("idf_mem_alu", 32'(id_fwd_a), 32'd2);
        chk("idf_mem_alu_pc", 32'(pc_en), 32'd1);
        next(); idle();
        mem_regwrite = 1'b1; mem_memread = 1'b1; mem_wn = 5'd7; wb_regwrite = 1'b1; wb_wn = 5'd7;
        id_set(6'h05, 6'h00, 5'd7, 5'd3, 1'b0);
        settle();
        chk("idf_mem_load", 32'(id_fwd_a), 32'd1);
        chk("idf_mem_load_pc", 32'(pc_en), 32'd0);

        // multu ; nop ; mflo with MUL_LAT=4
        next(); idle(); rst = 1'b1;
        next(); idle();
        ex_multu = 1'b1;
        settle();
        chk("mul_a_busy", 32'(mul_busy), 32'd1);
        for (int c = 0; c < 3; c++) begin
            next(); idle();
            id_set(6'h00, 6'h12, 5'd0, 5'd0, 1'b0);
            settle();
            chk("mul_busy_hold", 32'(mul_busy), 32'd1);
            chk("mflo_stall", 32'(pc_en), 32'd0);
        end
        next(); idle();
        id_set(6'h00, 6'h12, 5'd0, 5'd0, 1'b0);
        settle();
        chk("mul_done_busy", 32'(mul_busy), 32'd0);
        chk("mflo_go", 32'(pc_en), 32'd1);
        chk("mul_stall_cnt", 32'(stall_cnt), 32'd3);

        // writes to r0 never create hazards
        next(); idle();
        mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_regwrite = 1'b1; ex_memread = 1'b1;
        id_set(6'h04, 6'h00, 5'd0, 5'd0, 1'b0);
        settle();
        chk("r0_fwd_a", 32'(fwd_a), 32'd0);
        chk("r0_pc_en", 32'(pc_en), 32'd1);

        // reset in the middle of a multiply
        next(); idle(); ex_multu = 1'b1;
        next(); idle(); id_set(6'h00, 6'h12, 5'd0, 5'd0, 1'b0);
        settle();
        chk("mid_mul_stall", 32'(pc_en), 32'd0);
        next(); idle(); rst = 1'b1; id_set(6'h00, 6'h12, 5'd0, 5'd0, 1'b0);
        settle();
        chk("rst_mul_busy", 32'(mul_busy), 32'd0);
        next(); idle(); id_set(6'h00, 6'h12, 5'd0, 5'd0, 1'b0);
        settle();
        chk("post_rst_busy", 32'(mul_busy), 32'd0);
        chk("post_rst_cnt", 32'(stall_cnt), 32'd0);
        chk("post_rst_pc_en", 32'(pc_en), 32'd1);

        // randomized traffic, small register range so hazards are frequent
        for (int n = 0; n < N_RAND; n++) begin
            next();
            rst          = ($urandom_range(0, 1499) == 0);
            id_opcode    = op_tab[$urandom_range(0, 7)];
            id_funct     = fn_tab[$urandom_range(0, 5)];
            id_rs        = 5'($urandom_range(0, 5));
            id_rt        = 5'($urandom_range(0, 5));
            id_taken     = 1'($urandom_range(0, 1));
            ex_rs        = 5'($urandom_range(0, 5));
            ex_rt        = 5'($urandom_range(0, 5));
            ex_memread   = 1'($urandom_range(0, 1));
            ex_regwrite  = 1'($urandom_range(0, 1));
            ex_wn        = 5'($urandom_range(0, 5));
            ex_multu     = (m_cnt == 0) && ($urandom_range(0, 7) == 0);
            mem_regwrite = 1'($urandom_range(0, 1));
            mem_memread  = 1'($urandom_range(0, 1));
            mem_wn       = 5'($urandom_range(0, 5));
            wb_regwrite  = 1'($urandom_range(0, 1));
            wb_wn        = 5'($urandom_range(0, 5));
        end
        next();
        settle();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
